// File: rtl/crc_frame_sequencer.sv
// Byte-stream sequencer: forwards payload bytes and appends one CRC-8 byte per frame.
// Optional macro CRC_FRAME_COUNT_EN adds frame_count (CRC bytes taken downstream).
module crc_frame_sequencer #(
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  generator,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy
`ifdef CRC_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_crc;
    logic [7:0]  r_gen;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic        w_slot_free;
    logic        w_accept;
    logic [7:0]  w_gen_use;
    logic [7:0]  w_crc_nxt;

    function automatic logic [7:0] f_step(input logic [7:0] crc,
                                          input logic [7:0] b,
                                          input logic [7:0] g);
        logic [7:0] x;
        x = crc ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ g) : (x << 1);
        return x;
    endfunction

    assign w_slot_free = !r_m_valid | m_ready;
    assign s_ready     = w_slot_free & (r_state != APPEND);
    assign w_accept    = s_valid & s_ready;
    // The first byte of a frame uses the live generator; it is latched for the rest.
    assign w_gen_use   = (r_state == IDLE) ? generator : r_gen;
    assign w_crc_nxt   = f_step(r_crc, s_data, w_gen_use);

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign busy    = (r_state != IDLE) | r_m_valid;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DATA: if (w_accept) w_state_nxt = s_last ? APPEND : DATA;
            APPEND:     if (w_slot_free) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc     <= INIT;
            r_gen     <= 8'h00;
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_accept) begin
            r_m_data  <= s_data;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            r_crc     <= w_crc_nxt;
            if (r_state == IDLE)
                r_gen <= generator;
        end else if (r_state == APPEND && w_slot_free) begin
            r_m_data  <= r_crc;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b1;
            r_crc     <= INIT;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

`ifdef CRC_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_frame_count <= 16'h0000;
        else if (r_m_valid & m_ready & r_m_last)
            r_frame_count <= r_frame_count + 16'h0001;
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Self-checking bench for crc_frame_sequencer: directed frames plus randomized traffic
// against a bit-serial polynomial-division reference and an expected output queue.
module tb_crc_frame_sequencer;

    localparam logic [7:0] TB_INIT = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] generator = 8'h00;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       busy;
`ifdef CRC_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    crc_frame_sequencer #(.INIT(TB_INIT)) dut (
        .clk(clk),
        .rst(rst),
        .generator(generator),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_ready(m_ready),
        .busy(busy)
`ifdef CRC_FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] fbuf[$];
    logic [7:0] fgen;
    bit         app_pend;
    int         frames_done;
    int         outs_done;
    int         fc_base;
    logic [7:0] last_crc;
    int         run_len;
    int         max_run;
    int         cyc;
    bit         acc_flag;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Remainder of the message polynomial, fed one bit at a time MSB-first.
    function automatic logic [7:0] crc_ref(input logic [7:0] msg[$], input logic [7:0] g);
        logic [7:0] r;
        logic       fb;
        r = TB_INIT;
        foreach (msg[k])
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[k][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ g;
            end
        return r;
    endfunction

    task automatic set_ready(input int rm);
        case (rm)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = (cyc % 3 == 0);
        endcase
    endtask

    task automatic cycle();
        logic pv, pr, pl, sv, sr, sl, crc_load, exp_mv;
        logic [7:0] pd, sd, g;
        logic [8:0] e;
        #1;
        pv = m_valid; pr = m_ready; pl = m_last; pd = m_data;
        sv = s_valid; sr = s_ready; sl = s_last; sd = s_data; g = generator;
        chk("s_ready", 16'(sr), 16'((!pv | pr) & !app_pend));
        crc_load = app_pend & (!pv | pr);
        @(posedge clk);
        #1;
        cyc++;
        acc_flag = sv & sr;
        if (pv & pr) begin
            chk("out_avail", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_byte", 16'({pl, pd}), 16'(e));
            end
            outs_done++;
            if (pl) begin
                frames_done++;
                last_crc = pd;
            end
        end
        if (pv & !pr)
            chk("hold", 16'({m_valid, m_last, m_data}), 16'({1'b1, pl, pd}));
        if (crc_load) app_pend = 1'b0;
        if (acc_flag) begin
            chk("load", 16'({m_last, m_data}), 16'({1'b0, sd}));
            if (fbuf.size() == 0) fgen = g;
            fbuf.push_back(sd);
            exp_q.push_back({1'b0, sd});
            if (sl) begin
                exp_q.push_back({1'b1, crc_ref(fbuf, fgen)});
                fbuf.delete();
                app_pend = 1'b1;
            end
        end
        exp_mv = acc_flag | crc_load | (pv & !pr);
        chk("m_valid", 16'(m_valid), 16'(exp_mv));
        chk("busy", 16'(busy), 16'((fbuf.size() != 0) | app_pend | exp_mv));
        run_len = m_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
        m_ready = 1'b1; generator = 8'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0; s_valid = 1'b0;
        exp_q.delete(); fbuf.delete(); app_pend = 1'b0; run_len = 0;
        fc_base = frames_done;
        #1;
        chk("rst_m_valid", 16'(m_valid), 16'd0);
        chk("rst_m_last", 16'(m_last), 16'd0);
        chk("rst_m_data", 16'(m_data), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_s_ready", 16'(s_ready), 16'd1);
`ifdef CRC_FRAME_COUNT_EN
        chk("rst_frame_count", frame_count, 16'd0);
`endif
    endtask

    task automatic run_frame(input logic [7:0] q[$], input logic [7:0] g0, input logic [7:0] g1,
                             input bit do_last, input int vm, input int rm);
        int idx, guard;
        idx = 0; guard = 0;
        while (idx < q.size() && guard < 500) begin
            generator = (idx == 0) ? g0 : g1;
            s_valid   = (vm == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_data    = q[idx];
            s_last    = do_last && (idx == q.size() - 1);
            set_ready(rm);
            cycle();
            if (acc_flag) idx++;
            guard++;
        end
        if (idx < q.size()) chk("frame_timeout", 16'(idx), 16'(q.size()));
        // Junk on the upstream side while nothing is offered must be ignored.
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom); generator = 8'($urandom);
    endtask

    task automatic drain(input int rm);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 200) begin
            s_valid = 1'b0;
            set_ready(rm);
            cycle();
            guard++;
        end
        chk("drain_empty", 16'(exp_q.size()), 16'd0);
        chk("idle_busy", 16'(busy), 16'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] q2[$];
        string s;
        int f0, o0;
        s = "123456789";
        frames_done = 0; outs_done = 0; cyc = 0; max_run = 0; run_len = 0;
        app_pend = 1'b0; fgen = 8'h00; last_crc = 8'h00; fc_base = 0;

        do_reset();

        // Check value frame, streaming with no bubble
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(s[i]);
        max_run = 0;
        run_frame(q, 8'h07, 8'h07, 1'b1, 0, 0);
        drain(0);
        chk("check_crc", 16'(last_crc), 16'hF4);
        chk("run_length", 16'(max_run), 16'd10);

        // Single-byte frame
        f0 = frames_done; o0 = outs_done;
        q.delete(); q.push_back(8'h01);
        run_frame(q, 8'h07, 8'h07, 1'b1, 0, 0);
        drain(0);
        chk("single_crc", 16'(last_crc), 16'h07);
        chk("single_outs", 16'(outs_done - o0), 16'd2);
        chk("single_frames", 16'(frames_done - f0), 16'd1);

        // Backpressure pattern 1,0,0
        q.delete(); q.push_back(8'hAA); q.push_back(8'h55);
        o0 = outs_done;
        run_frame(q, 8'h07, 8'h07, 1'b1, 0, 2);
        drain(2);
        chk("stall_crc", 16'(last_crc), 16'(crc_ref(q, 8'h07)));
        chk("stall_outs", 16'(outs_done - o0), 16'd3);

        // Generator changes mid-frame; next frame picks up the new one
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        run_frame(q, 8'h07, 8'h31, 1'b1, 0, 0);
        drain(0);
        chk("gen_latched", 16'(last_crc), 16'(crc_ref(q, 8'h07)));
        q2.delete();
        for (int i = 0; i < 3; i++) q2.push_back(8'($urandom));
        run_frame(q2, 8'h31, 8'h07, 1'b1, 0, 0);
        drain(0);
        chk("gen_next", 16'(last_crc), 16'(crc_ref(q2, 8'h31)));

        // Reset abandons a partial frame
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(s[i]);
        run_frame(q, 8'h07, 8'h07, 1'b0, 0, 0);
        do_reset();
        f0 = frames_done;
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(s[i]);
        run_frame(q, 8'h07, 8'h07, 1'b1, 1, 1);
        drain(1);
        chk("abort_crc", 16'(last_crc), 16'hF4);
        chk("abort_frames", 16'(frames_done - f0), 16'd1);
`ifdef CRC_FRAME_COUNT_EN
        chk("frame_count_after_abort", frame_count, 16'(frames_done - fc_base));
`endif

        // Randomized back-to-back frames
        f0 = frames_done;
        for (int n = 0; n < 25; n++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) q.push_back(8'($urandom));
            run_frame(q, 8'($urandom), 8'($urandom), 1'b1, 1, 1);
        end
        drain(1);
        chk("random_frames", 16'(frames_done - f0), 16'd25);

`ifdef CRC_FRAME_COUNT_EN
        do_reset();
        for (int n = 0; n < 3; n++) begin
            q.delete(); q.push_back(8'($urandom)); q.push_back(8'($urandom));
            run_frame(q, 8'h07, 8'h07, 1'b1, 0, 0);
        end
        drain(0);
        chk("frame_count_3", frame_count, 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
